// File: rtl/cpu_pkg.sv
// Shared definitions for the unfolded adding-machine CPU: state encoding,
// opcodes and the 26-bit state-vector layout used by ppi/ppo and the register.
package cpu_pkg;

    // Controller states; codes 7..15 are unused and treated as illegal.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_LDA    = 4'd3,
        ST_STA    = 4'd4,
        ST_ADD    = 4'd5,
        ST_JMP    = 4'd6
    } fsmState_t;

    // Opcode lives in ir[7:6], operand address in ir[5:0].
    localparam logic [1:0] OP_LDA = 2'b00;
    localparam logic [1:0] OP_STA = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_JMP = 2'b11;

    // State-vector field positions.
    localparam int unsigned STATE_W = 26;
    localparam int unsigned AC_MSB  = 25;
    localparam int unsigned AC_LSB  = 18;
    localparam int unsigned IR_MSB  = 17;
    localparam int unsigned IR_LSB  = 10;
    localparam int unsigned PC_MSB  = 9;
    localparam int unsigned PC_LSB  = 4;
    localparam int unsigned FSM_MSB = 3;
    localparam int unsigned FSM_LSB = 0;

    // Packed view of the state vector; member order gives the same bit
    // layout as the offsets above (ac in the top byte, fsm in the low nibble).
    typedef struct packed {
        logic [7:0] ac;
        logic [7:0] ir;
        logic [5:0] pc;
        logic [3:0] fsm;
    } cpuState_t;

    // Map an opcode to the execute state that handles it.
    function automatic logic [3:0] execState(input logic [1:0] op);
        logic [3:0] st;
        case (op)
            OP_LDA:  st = ST_LDA;
            OP_STA:  st = ST_STA;
            OP_ADD:  st = ST_ADD;
            default: st = ST_JMP;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/cpu_core_comb.sv
// Purely combinational next-state and memory-interface logic of the CPU.
// Everything here is a function of the present state and the read data only,
// so the block can be exercised as stand-alone combinational logic.
module cpu_core_comb
    import cpu_pkg::*;
(
    input  logic [7:0]         dataIn,
    input  logic [STATE_W-1:0] presentState,
    output logic [5:0]         adrBus,
    output logic               rdMem,
    output logic               wrMem,
    output logic [7:0]         dataOut,
    output logic [STATE_W-1:0] nextState
);

    cpuState_t ps;
    cpuState_t ns;
    logic [5:0] operandAdr;
    logic [1:0] opcode;

    assign ps         = cpuState_t'(presentState);
    assign operandAdr = ps.ir[5:0];
    assign opcode     = ps.ir[7:6];

    // Per-state address, strobes and next-state; unwritten fields hold.
    always_comb begin
        ns     = ps;
        adrBus = ps.pc;
        rdMem  = 1'b0;
        wrMem  = 1'b0;
        ns.fsm = ST_FETCH;
        case (ps.fsm)
            ST_IDLE: begin
                ns.fsm = ST_FETCH;
            end
            ST_FETCH: begin
                rdMem  = 1'b1;
                ns.ir  = dataIn;
                ns.pc  = ps.pc + 6'd1;
                ns.fsm = ST_DECODE;
            end
            ST_DECODE: begin
                adrBus = operandAdr;
                ns.fsm = execState(opcode);
            end
            ST_LDA: begin
                adrBus = operandAdr;
                rdMem  = 1'b1;
                ns.ac  = dataIn;
            end
            ST_STA: begin
                adrBus = operandAdr;
                wrMem  = 1'b1;
            end
            ST_ADD: begin
                adrBus = operandAdr;
                rdMem  = 1'b1;
                ns.ac  = ps.ac + dataIn;
            end
            ST_JMP: begin
                adrBus = operandAdr;
                ns.pc  = operandAdr;
            end
            default: begin
                // Illegal codes recover to FETCH with every data field held.
                adrBus = ps.pc;
            end
        endcase
    end

    // Write data is only driven while a store is in progress.
    always_comb begin
        dataOut = wrMem ? ps.ac : '0;
    end

    assign nextState = STATE_W'(ns);

endmodule

// File: rtl/cpu_net.sv
// Top of the full-scan CPU: selects the present state from ppi (test mode)
// or the internal state register (functional mode) and feeds the
// combinational core. The register always loads ppo.
module cpu_net
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               test_mode,
    input  logic [7:0]         data_bus_in,
    input  logic [STATE_W-1:0] ppi,
    output logic [5:0]         adr_bus,
    output logic               rd_mem,
    output logic               wr_mem,
    output logic [7:0]         data_bus_out,
    output logic [STATE_W-1:0] ppo
);

    logic [STATE_W-1:0] stateReg;
    logic [STATE_W-1:0] presentState;

    // Present-state mux; reset only reaches the outputs through stateReg,
    // so the test-mode path is untouched by reset.
    always_comb begin
        presentState = test_mode ? ppi : stateReg;
    end

    cpu_core_comb uCore (
        .dataIn       (data_bus_in),
        .presentState (presentState),
        .adrBus       (adr_bus),
        .rdMem        (rd_mem),
        .wrMem        (wr_mem),
        .dataOut      (data_bus_out),
        .nextState    (ppo)
    );

    // State register: async clear to all-zero (IDLE), otherwise load ppo.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg <= '0;
        end else begin
            stateReg <= ppo;
        end
    end

    // Read and write strobes are mutually exclusive by construction.
    always_comb begin
        assert (!(rd_mem && wr_mem));
    end

endmodule

// File: tb/tb_cpu_net.sv
// Directed self-checking bench for cpu_net: combinational core via ppi/ppo,
// then a short functional program and an asynchronous reset abort.
module tb_cpu_net;

    logic        clk;
    logic        reset;
    logic        testMode;
    logic [7:0]  dataBusIn;
    logic [25:0] ppi;
    logic [5:0]  adrBus;
    logic        rdMem;
    logic        wrMem;
    logic [7:0]  dataBusOut;
    logic [25:0] ppo;

    logic        useMem;
    logic [7:0]  tbData;
    logic [7:0]  mem [64];

    int total;
    int bad;

    cpu_net dut (
        .clk          (clk),
        .reset        (reset),
        .test_mode    (testMode),
        .data_bus_in  (dataBusIn),
        .ppi          (ppi),
        .adr_bus      (adrBus),
        .rd_mem       (rdMem),
        .wr_mem       (wrMem),
        .data_bus_out (dataBusOut),
        .ppo          (ppo)
    );

    assign dataBusIn = useMem ? mem[adrBus] : tbData;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        testMode = 1'b0;
        useMem   = 1'b0;
        tbData   = 8'h5A;
        reset    = 1'b0;
        #3;
        total++; if (adrBus !== 6'h00) begin bad++; $display("FAIL reset_adr got=%h want=%h", adrBus, 6'h00); end
        total++; if (rdMem !== 1'b0 || wrMem !== 1'b0) begin bad++; $display("FAIL reset_strobes got rd=%b wr=%b want 0 0", rdMem, wrMem); end
        total++; if (dataBusOut !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h want=%h", dataBusOut, 8'h00); end
        total++; if (ppo !== {8'h00, 8'h00, 6'h00, 4'h1}) begin bad++; $display("FAIL reset_ppo got=%h want=%h", ppo, {8'h00, 8'h00, 6'h00, 4'h1}); end
    endtask

    task automatic test_fetch();
        testMode = 1'b1;
        ppi      = {8'h00, 8'h00, 6'h05, 4'h1};
        tbData   = 8'h8A;
        #1;
        total++; if (adrBus !== 6'h05) begin bad++; $display("FAIL fetch_adr got=%h want=%h", adrBus, 6'h05); end
        total++; if (rdMem !== 1'b1 || wrMem !== 1'b0) begin bad++; $display("FAIL fetch_strobes got rd=%b wr=%b want 1 0", rdMem, wrMem); end
        total++; if (ppo !== {8'h00, 8'h8A, 6'h06, 4'h2}) begin bad++; $display("FAIL fetch_ppo got=%h want=%h", ppo, {8'h00, 8'h8A, 6'h06, 4'h2}); end
        // pc wraps 63 -> 0 on fetch
        ppi    = {8'h11, 8'h22, 6'h3F, 4'h1};
        tbData = 8'hC3;
        #1;
        total++; if (ppo !== {8'h11, 8'hC3, 6'h00, 4'h2}) begin bad++; $display("FAIL fetch_pcwrap_ppo got=%h want=%h", ppo, {8'h11, 8'hC3, 6'h00, 4'h2}); end
    endtask

    task automatic test_add();
        testMode = 1'b1;
        ppi      = {8'hFF, 8'h8A, 6'h06, 4'h5};
        tbData   = 8'h02;
        #1;
        total++; if (adrBus !== 6'h0A) begin bad++; $display("FAIL add_adr got=%h want=%h", adrBus, 6'h0A); end
        total++; if (rdMem !== 1'b1 || wrMem !== 1'b0) begin bad++; $display("FAIL add_strobes got rd=%b wr=%b want 1 0", rdMem, wrMem); end
        total++; if (ppo !== {8'h01, 8'h8A, 6'h06, 4'h1}) begin bad++; $display("FAIL add_ppo got=%h want=%h", ppo, {8'h01, 8'h8A, 6'h06, 4'h1}); end
        // FF + 01 wraps to 00
        ppi    = {8'hFF, 8'h81, 6'h07, 4'h5};
        tbData = 8'h01;
        #1;
        total++; if (ppo !== {8'h00, 8'h81, 6'h07, 4'h1}) begin bad++; $display("FAIL add_wrap_ppo got=%h want=%h", ppo, {8'h00, 8'h81, 6'h07, 4'h1}); end
    endtask

    task automatic test_lda_sta();
        testMode = 1'b1;
        ppi      = {8'h11, 8'h0C, 6'h20, 4'h3};
        tbData   = 8'h5A;
        #1;
        total++; if (adrBus !== 6'h0C || rdMem !== 1'b1) begin bad++; $display("FAIL lda_bus got adr=%h rd=%b want adr=0c rd=1", adrBus, rdMem); end
        total++; if (ppo !== {8'h5A, 8'h0C, 6'h20, 4'h1}) begin bad++; $display("FAIL lda_ppo got=%h want=%h", ppo, {8'h5A, 8'h0C, 6'h20, 4'h1}); end
        ppi    = {8'h3C, 8'h45, 6'h10, 4'h4};
        tbData = 8'hA5;
        #1;
        total++; if (adrBus !== 6'h05) begin bad++; $display("FAIL sta_adr got=%h want=%h", adrBus, 6'h05); end
        total++; if (wrMem !== 1'b1 || rdMem !== 1'b0) begin bad++; $display("FAIL sta_strobes got rd=%b wr=%b want 0 1", rdMem, wrMem); end
        total++; if (dataBusOut !== 8'h3C) begin bad++; $display("FAIL sta_dout got=%h want=%h", dataBusOut, 8'h3C); end
        total++; if (ppo !== {8'h3C, 8'h45, 6'h10, 4'h1}) begin bad++; $display("FAIL sta_ppo got=%h want=%h", ppo, {8'h3C, 8'h45, 6'h10, 4'h1}); end
    endtask

    task automatic test_jmp();
        testMode = 1'b1;
        tbData   = 8'h99;
        ppi      = {8'h00, 8'hE7, 6'h3F, 4'h2};
        #1;
        total++; if (adrBus !== 6'h27 || rdMem !== 1'b0 || wrMem !== 1'b0) begin bad++; $display("FAIL decode_bus got adr=%h rd=%b wr=%b want 27 0 0", adrBus, rdMem, wrMem); end
        total++; if (ppo !== {8'h00, 8'hE7, 6'h3F, 4'h6}) begin bad++; $display("FAIL decode_jmp_ppo got=%h want=%h", ppo, {8'h00, 8'hE7, 6'h3F, 4'h6}); end
        ppi = {8'h00, 8'hE7, 6'h3F, 4'h6};
        #1;
        total++; if (ppo !== {8'h00, 8'hE7, 6'h27, 4'h1}) begin bad++; $display("FAIL jmp_ppo got=%h want=%h", ppo, {8'h00, 8'hE7, 6'h27, 4'h1}); end
        // DECODE for the other opcodes
        ppi = {8'h00, 8'h45, 6'h01, 4'h2};
        #1;
        total++; if (ppo[3:0] !== 4'h4) begin bad++; $display("FAIL decode_sta got=%h want=%h", ppo[3:0], 4'h4); end
        ppi = {8'h00, 8'h8A, 6'h01, 4'h2};
        #1;
        total++; if (ppo[3:0] !== 4'h5) begin bad++; $display("FAIL decode_add got=%h want=%h", ppo[3:0], 4'h5); end
        ppi = {8'h00, 8'h02, 6'h01, 4'h2};
        #1;
        total++; if (ppo[3:0] !== 4'h3) begin bad++; $display("FAIL decode_lda got=%h want=%h", ppo[3:0], 4'h3); end
    endtask

    task automatic test_idle_illegal();
        testMode = 1'b1;
        tbData   = 8'h77;
        ppi      = {8'h12, 8'h34, 6'h15, 4'h0};
        #1;
        total++; if (adrBus !== 6'h15 || rdMem !== 1'b0 || wrMem !== 1'b0) begin bad++; $display("FAIL idle_bus got adr=%h rd=%b wr=%b want 15 0 0", adrBus, rdMem, wrMem); end
        total++; if (ppo !== {8'h12, 8'h34, 6'h15, 4'h1}) begin bad++; $display("FAIL idle_ppo got=%h want=%h", ppo, {8'h12, 8'h34, 6'h15, 4'h1}); end
        for (int s = 7; s <= 15; s++) begin
            ppi = {8'h9C, 8'h77, 6'h3F, 4'(s)};
            #1;
            total++; if (adrBus !== 6'h3F || rdMem !== 1'b0 || wrMem !== 1'b0 || dataBusOut !== 8'h00) begin bad++; $display("FAIL illegal_bus fsm=%0d got adr=%h rd=%b wr=%b dout=%h want 3f 0 0 00", s, adrBus, rdMem, wrMem, dataBusOut); end
            total++; if (ppo !== {8'h9C, 8'h77, 6'h3F, 4'h1}) begin bad++; $display("FAIL illegal_ppo fsm=%0d got=%h want=%h", s, ppo, {8'h9C, 8'h77, 6'h3F, 4'h1}); end
        end
    endtask

    task automatic test_reset_bypass();
        testMode = 1'b1;
        reset    = 1'b0;
        ppi      = {8'h00, 8'h00, 6'h05, 4'h1};
        tbData   = 8'h8A;
        #1;
        total++; if (adrBus !== 6'h05 || rdMem !== 1'b1) begin bad++; $display("FAIL bypass_bus got adr=%h rd=%b want 05 1", adrBus, rdMem); end
        total++; if (ppo !== {8'h00, 8'h8A, 6'h06, 4'h2}) begin bad++; $display("FAIL bypass_ppo got=%h want=%h", ppo, {8'h00, 8'h8A, 6'h06, 4'h2}); end
    endtask

    // Program: LDA 02; ADD 02; (02)=07; STA 03. The word at 02 is also
    // fetched as an instruction (LDA 07), so 07 holds 0E to keep the sum.
    task automatic loadProgram();
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[0] = 8'h02;
        mem[1] = 8'h82;
        mem[2] = 8'h07;
        mem[3] = 8'h43;
        mem[7] = 8'h0E;
    endtask

    task automatic startFunctional();
        loadProgram();
        useMem   = 1'b1;
        testMode = 1'b0;
        reset    = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    task automatic test_program();
        int writes;
        writes = 0;
        startFunctional();
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 6) begin
                total++; if (adrBus !== 6'h02 || rdMem !== 1'b1 || ppo[25:18] !== 8'h0E) begin bad++; $display("FAIL prog_add got adr=%h rd=%b ac'=%h want 02 1 0e", adrBus, rdMem, ppo[25:18]); end
            end
            if (cyc < 12 && wrMem === 1'b1) writes++;
        end
        total++; if (writes !== 0) begin bad++; $display("FAIL prog_early_write got=%0d want=0", writes); end
        total++; if (wrMem !== 1'b1 || rdMem !== 1'b0) begin bad++; $display("FAIL prog_sta_strobe got rd=%b wr=%b want 0 1", rdMem, wrMem); end
        total++; if (adrBus !== 6'h03 || dataBusOut !== 8'h0E) begin bad++; $display("FAIL prog_sta_data got adr=%h dout=%h want 03 0e", adrBus, dataBusOut); end
    endtask

    task automatic test_reset_mid_add();
        startFunctional();
        repeat (6) @(posedge clk);
        #1;
        total++; if (adrBus !== 6'h02 || rdMem !== 1'b1) begin bad++; $display("FAIL abort_pre got adr=%h rd=%b want 02 1", adrBus, rdMem); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (adrBus !== 6'h00 || rdMem !== 1'b0 || wrMem !== 1'b0) begin bad++; $display("FAIL abort_bus got adr=%h rd=%b wr=%b want 00 0 0", adrBus, rdMem, wrMem); end
        total++; if (ppo !== {8'h00, 8'h00, 6'h00, 4'h1}) begin bad++; $display("FAIL abort_ppo got=%h want=%h", ppo, {8'h00, 8'h00, 6'h00, 4'h1}); end
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++; if (adrBus !== 6'h00 || rdMem !== 1'b1) begin bad++; $display("FAIL abort_fetch_bus got adr=%h rd=%b want 00 1", adrBus, rdMem); end
        total++; if (ppo !== {8'h00, 8'h02, 6'h01, 4'h2}) begin bad++; $display("FAIL abort_fetch_ppo got=%h want=%h", ppo, {8'h00, 8'h02, 6'h01, 4'h2}); end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b0;
        testMode = 1'b0;
        useMem   = 1'b0;
        tbData   = 8'h00;
        ppi      = '0;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        test_reset();
        reset = 1'b1;
        test_fetch();
        test_add();
        test_lda_sta();
        test_jmp();
        test_idle_illegal();
        test_reset_bypass();
        reset = 1'b1;
        test_program();
        test_reset_mid_add();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
